// File: rtl/nn_pkg.sv
// Shared constants, word type and readout FSM encoding for the output stage.
package nn_pkg;
    localparam int DATA_W  = 16;
    localparam int NUM_OUT = 10;
    localparam int ADDR_W  = 6;
    localparam int LANE_W  = 4;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        FIN     = 3'd4
    } rd_state_e;
endpackage

// File: rtl/output_reader_argmax_tracker.sv
// Running signed argmax over one sample's lanes. Built only when
// OUTPUT_READER_ARGMAX_EN is defined; otherwise this file contributes nothing.
`ifdef OUTPUT_READER_ARGMAX_EN
module argmax_tracker
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  word_t             in_data,
    input  logic [LANE_W-1:0] in_lane,
    output logic [LANE_W-1:0] max_idx,
    output word_t             max_val
);
    logic [LANE_W-1:0] r_max_idx;
    word_t             r_max_val;
    logic              w_take;

    // Lane 0 seeds the maximum; strictly-greater keeps the lower lane on ties.
    assign w_take = (in_lane == '0) || (in_data > r_max_val);

    // Update the running maximum on each accepted word.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_max_idx <= '0;
            r_max_val <= '0;
        end else if (in_valid && w_take) begin
            r_max_idx <= in_lane;
            r_max_val <= in_data;
        end
    end

    assign max_idx = r_max_idx;
    assign max_val = r_max_val;
endmodule
`endif

// File: rtl/output_reader.sv
// Drains the 10-lane output SRAM one sample at a time and streams each lane
// over valid/ready. Define OUTPUT_READER_ARGMAX_EN to add per-sample argmax.
//
// Handshake: a word transfers on a clock edge where out_valid && out_ready;
// once out_valid rises it stays high with out_data/out_lane/out_sample/
// out_last stable until that transfer happens.
module output_reader
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_samples,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [NUM_OUT*DATA_W-1:0] rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [LANE_W-1:0]         out_lane,
    output logic [ADDR_W-1:0]         out_sample,
    output logic                      out_last,
    output logic                      class_valid,
    output logic [LANE_W-1:0]         class_idx,
    output logic [DATA_W-1:0]         class_score,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                dbg_state
);
    rd_state_e         r_state;
    rd_state_e         w_next_state;
    logic [ADDR_W:0]   r_num;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [LANE_W-1:0] r_lane;
    word_t             r_buf [NUM_OUT];

    logic              w_hs;
    logic              w_last_lane;
    logic              w_last_sample;
    word_t             w_out_data;

    assign w_hs          = (r_state == STREAM) && out_ready;
    assign w_last_lane   = (r_lane == LANE_W'(NUM_OUT-1));
    assign w_last_sample = (({1'b0, r_rd_addr} + (ADDR_W+1)'(1)) == r_num);

    // State register plus sample count, address and lane counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_num     <= '0;
            r_rd_addr <= '0;
            r_lane    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num     <= num_samples;
                        r_rd_addr <= '0;
                    end
                end
                CAPTURE: r_lane <= '0;
                STREAM: begin
                    if (w_hs) begin
                        if (!w_last_lane) begin
                            r_lane <= r_lane + LANE_W'(1);
                        end else begin
                            r_lane <= '0;
                            if (!w_last_sample) r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane buffer: the SRAM q bus is only meaningful in CAPTURE.
    always_ff @(posedge clk) begin
        if (r_state == CAPTURE) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_buf[i] <= rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic and stream outputs decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        w_out_data   = '0;
        out_lane     = '0;
        out_last     = 1'b0;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        case (r_state)
            IDLE:    if (start) w_next_state = (num_samples == '0) ? FIN : WAIT;
            WAIT:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = STREAM;
            STREAM: begin
                out_valid  = 1'b1;
                w_out_data = r_buf[r_lane];
                out_lane   = r_lane;
                out_last   = w_last_lane && w_last_sample;
                if (w_hs && w_last_lane) w_next_state = w_last_sample ? FIN : WAIT;
            end
            FIN: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign rd_addr    = r_rd_addr;
    assign out_sample = r_rd_addr;
    assign out_data   = w_out_data;
    assign dbg_state  = r_state;

`ifdef OUTPUT_READER_ARGMAX_EN
    logic              r_cls_pend;
    logic [LANE_W-1:0] r_cls_idx;
    word_t             r_cls_score;
    logic [LANE_W-1:0] w_max_idx;
    word_t             w_max_val;

    argmax_tracker u_argmax (
        .clk      (clk),
        .reset    (reset),
        .clear    (r_state == CAPTURE),
        .in_valid (w_hs),
        .in_data  (w_out_data),
        .in_lane  (r_lane),
        .max_idx  (w_max_idx),
        .max_val  (w_max_val)
    );

    // Pulse after the last lane transfers, then hold the result until the next pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cls_pend  <= 1'b0;
            r_cls_idx   <= '0;
            r_cls_score <= '0;
        end else begin
            r_cls_pend <= w_hs && w_last_lane;
            if (r_cls_pend) begin
                r_cls_idx   <= w_max_idx;
                r_cls_score <= w_max_val;
            end
        end
    end

    assign class_valid = r_cls_pend;
    assign class_idx   = r_cls_pend ? w_max_idx : r_cls_idx;
    assign class_score = r_cls_pend ? w_max_val : r_cls_score;
`else
    assign class_valid = 1'b0;
    assign class_idx   = '0;
    assign class_score = '0;
`endif
endmodule

// File: doc/output_reader.md
Name: output_reader

Overview:
- Drains classification results from the 10-lane output SRAM bank after the second sigmoid stage has written them.
- For each sample address it issues a read and latches all 10 lanes. It then streams them out one word at a time over a valid/ready interface.
- Optionally tracks the per-sample argmax (predicted class).
- Sits on the output SRAM read port, opposite the sigmoid-stage writer.

Parameters:
- NUM_OUT, 10, number of output lanes (one output SRAM per lane).
- DATA_W, 16, signed word width of each lane.
- ADDR_W, 6, output SRAM address width (depth 2**ADDR_W = 64).
- LANE_W, 4, width of the lane index (ceil(log2(NUM_OUT))).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to begin a readout; sampled only in IDLE.
- num_samples  in  ADDR_W+1  number of sample addresses to read (0..64); latched on accepted start.
- rd_addr  out  ADDR_W  output SRAM address.
- rd_data  in  NUM_OUT*DATA_W  concatenated SRAM q buses; lane 0 in the LSBs; valid 1 cycle after rd_addr.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  signed lane value.
- out_lane  out  LANE_W  lane index of out_data.
- out_sample  out  ADDR_W  sample address of out_data.
- out_last  out  1  high on lane NUM_OUT-1 of the final sample.
- class_valid  out  1  one-cycle pulse: class_idx/class_score valid.
- class_idx  out  LANE_W  argmax lane of the just-finished sample.
- class_score  out  DATA_W  value at class_idx.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when readout completes.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - rd_addr, out_valid, out_data, out_lane, out_sample, out_last, class_valid, class_idx, class_score, busy and done all 0.
  - Counters cleared.
  - Applies mid-operation too: stream dropped, no done pulse.
- FSM states and transitions:
  - IDLE → if start: latch num_samples.
    - num_samples=0: go to FIN.
    - Otherwise: rd_addr=0, go to WAIT.
  - WAIT: one cycle covering SRAM read latency → CAPTURE.
  - CAPTURE: register all NUM_OUT lanes of rd_data into the lane buffer, lane counter=0 → STREAM.
  - STREAM: out_valid=1, out_data=buffer[lane], out_lane=lane, out_sample=rd_addr.
    - On out_valid&&out_ready with lane<NUM_OUT-1: lane+1.
    - On handshake at lane NUM_OUT-1, if more samples remain: rd_addr+1, out_valid drops, → WAIT.
    - On handshake at lane NUM_OUT-1 of the final sample: → FIN.
  - FIN: done=1 for one cycle → IDLE.
- Stream rules:
  - While out_valid=1 && out_ready=0, out_data, out_lane, out_sample and out_last hold stable.
  - out_valid never deasserts without a handshake.
  - Throughput: NUM_OUT words per sample at full ready, plus 2 bubble cycles per sample (WAIT, CAPTURE).
- Address bounds: rd_addr never exceeds num_samples-1. With num_samples=64, the last address is 63 and there is no wrap.
- start while busy=1 is ignored (no effect, no queueing).
- Latency: from accepted start to first out_valid is 3 cycles (IDLE→WAIT→CAPTURE→STREAM).
- rd_data is sampled only in CAPTURE. Other values on it are don't-care.

Optional Feature:
- Macro: OUTPUT_READER_ARGMAX_EN.
- Defined:
  - During STREAM, each handshake compares out_data, signed, against the running max.
  - Lane 0 initialises the max. Ties keep the lower lane.
  - class_valid pulses the cycle after the lane NUM_OUT-1 handshake, with class_idx/class_score for that sample.
  - class_idx/class_score hold until the next pulse.
- Undefined: class_valid, class_idx and class_score are tied to 0, and no comparator logic is built.

Decomposition:
- Package nn_pkg: DATA_W, NUM_OUT, ADDR_W, LANE_W constants; signed word typedef; output_reader state enum (IDLE, WAIT, CAPTURE, STREAM, FIN).
- Sub-module argmax_tracker:
  - Inputs: clk, reset, clear, in_valid, in_data, in_lane.
  - Outputs: max_idx, max_val.
  - Instantiated only under OUTPUT_READER_ARGMAX_EN.

Test Plan:
- Reset mid-stream:
  - Stimulus: start num_samples=4; assert reset=0 during sample 1, lane 5.
  - Required: next cycle all outputs 0 and busy=0; no done pulse; a new start reads from address 0.
- Basic readout:
  - Stimulus: preload address 0 lanes = 100,200,…,1000; start, num_samples=1; out_ready=1.
  - Required: out_valid 3 cycles after start; 10 words 100..1000 with out_lane 0..9; out_last on the 10th word; done 1 cycle later.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1…
  - Required: out_data/out_lane stable during stalls; all 10 words delivered exactly once, in order.
- Zero samples and full depth:
  - num_samples=0 → done the cycle after FIN is entered, out_valid never high.
  - num_samples=64 → 640 words; rd_addr ends at 63; out_sample 0..63.
- Argmax with OUTPUT_READER_ARGMAX_EN:
  - Lanes = -5,3,7,7,-32768,0,1,2,6,-1 → class_idx=2, class_score=7.
  - All lanes = -32768 → class_idx=0.
- Start while busy: pulse start again mid-STREAM → ignored; word count and done timing unchanged.
